alu_seq: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU. Keeps the existing 4-bit alu_ctrl encoding for ops 1-7 and adds:
  - signed/unsigned set-less-than
  - shifts
  - iterative multiply and divide
  - signed-overflow flag
  - start/done handshake
- Sits in the execute stage. The controller stalls on busy while a mult/div is in flight.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_muldiv.sv | 58 +++++
 rtl/alu_seq.sv | 114 +++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by the sequential ALU and its mult/div engine
package alu_pkg;
    localparam int OP_W = 4;
    typedef enum logic [OP_W-1:0] {
        OP_NONE  = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_LAND  = 4'd7,
        OP_SLTU  = 4'd8,
        OP_SLL   = 4'd9,
        OP_SRL   = 4'd10,
        OP_SRA   = 4'd11,
        OP_MULT  = 4'd12,
        OP_MULTU = 4'd13,
        OP_DIV   = 4'd14,
        OP_DIVU  = 4'd15
    } alu_op_e;
    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_e;
    function automatic logic is_md(input alu_op_e op);
        return op >= OP_MULT;
    endfunction
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative shift-add multiplier / restoring divider on operand magnitudes; rdy flags the final iteration
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             rdy
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0]   hi_r, lo_r, b_r, a_mag, b_mag;
    logic [WIDTH:0]     sum, trial, diff;
    logic [2*WIDTH-1:0] p_fix;
    logic [CW-1:0]      cnt;
    logic               active, div_r, neg_q, neg_r;
    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    assign sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
    assign trial = {hi_r, lo_r[WIDTH-1]};
    assign diff  = trial - {1'b0, b_r};
    assign rdy   = active && cnt == '0;
    assign p_fix = neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};
    // MIN/-1 and divide-by-zero fall out of the magnitude algorithm plus this sign fix
    assign lo    = div_r ? (neg_q ? -lo_r : lo_r) : p_fix[WIDTH-1:0];
    assign hi    = div_r ? (neg_r ? -hi_r : hi_r) : p_fix[2*WIDTH-1:WIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            b_r    <= '0;
            div_r  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (go) begin
            active <= 1'b1;
            cnt    <= CW'(WIDTH - 1);
            hi_r   <= '0;
            lo_r   <= a_mag;
            b_r    <= b_mag;
            div_r  <= is_div;
            neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= is_signed && a[WIDTH-1];
        end else if (active) begin
            cnt    <= cnt - 1'b1;
            active <= cnt != '0;
            {hi_r, lo_r} <= div_r ? {diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0], lo_r[WIDTH-2:0], ~diff[WIDTH]}
                                  : {sum, lo_r[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with single-cycle ops and an optional iterative mult/div behind a start/done handshake
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             zero,
    output logic             ovf
);
    localparam int SW = $clog2(WIDTH);
    alu_op_e          op;
    state_e           state;
    logic [WIDTH-1:0] sum, dif, res, a_r, b_r, md_lo, md_hi;
    logic [SW-1:0]    sh;
    logic             v, md_rdy, div_r, sgn_r, start_md;
    assign op       = alu_op_e'(alu_ctrl);
    assign sum      = a1 + a2;
    assign dif      = a1 - a2;
    assign sh       = a2[SW-1:0];
    assign start_md = start && MD_EN && is_md(op);
    always_comb begin
        res = '0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum;
                v   = (a1[WIDTH-1] == a2[WIDTH-1]) && (sum[WIDTH-1] != a1[WIDTH-1]);
            end
            OP_SUB: begin
                res = dif;
                v   = (a1[WIDTH-1] != a2[WIDTH-1]) && (dif[WIDTH-1] != a1[WIDTH-1]);
            end
            OP_AND:  res = a1 & a2;
            OP_OR:   res = a1 | a2;
            OP_NOR:  res = ~(a1 | a2);
            OP_SLT:  res = WIDTH'($signed(a1) < $signed(a2));
            OP_LAND: res = WIDTH'(a1 != '0 && a2 != '0);
            OP_SLTU: res = WIDTH'(a1 < a2);
            OP_SLL:  res = a1 << sh;
            OP_SRL:  res = a1 >> sh;
            OP_SRA:  res = $unsigned($signed(a1) >>> sh);
            default: res = '0;
        endcase
    end
    alu_muldiv #(.WIDTH(WIDTH)) u_md (
        .clk       (clk),
        .rst       (rst),
        .go        (state == LOAD),
        .is_div    (div_r),
        .is_signed (sgn_r),
        .a         (a_r),
        .b         (b_r),
        .lo        (md_lo),
        .hi        (md_hi),
        .rdy       (md_rdy)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_out <= '0;
            hi_out  <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            div_r   <= 1'b0;
            sgn_r   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_md) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        a_r   <= a1;
                        b_r   <= a2;
                        div_r <= alu_ctrl[1];
                        sgn_r <= ~alu_ctrl[0];
                    end else if (start) begin
                        done    <= 1'b1;
                        alu_out <= res;
                        hi_out  <= '0;
                        zero    <= res == '0;
                        ovf     <= v;
                    end
                end
                LOAD: state <= ITER;
                ITER: state <= md_rdy ? FIX : ITER;
                FIX: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    alu_out <= md_lo;
                    hi_out  <= md_hi;
                    zero    <= md_lo == '0;
                    ovf     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at WIDTH=32 with mult/div and WIDTH=8 without
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_ctrl;
    logic [31:0] a1, a2, alu_out, hi_out;
    logic        busy, done, zero, ovf;
    logic        s_start;
    logic [3:0]  s_ctrl;
    logic [7:0]  s_a1, s_a2, s_out, s_hi;
    logic        s_busy, s_done, s_zero, s_ovf;
    int          checks = 0;
    int          errors = 0;
    int          edges;
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, lo, hi;
        logic        ov;
        int          lat;
    } vec_t;
    vec_t vecs [21] = '{
        '{4'd6,  32'hFFFFFFFF, 32'd1,        32'd1,        32'd0,        1'b0, 0},
        '{4'd8,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0, 0},
        '{4'd11, 32'h80000000, 32'd4,        32'hF8000000, 32'd0,        1'b0, 0},
        '{4'd2,  32'h80000000, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b1, 0},
        '{4'd5,  32'd0,        32'd0,        32'hFFFFFFFF, 32'd0,        1'b0, 0},
        '{4'd7,  32'd5,        32'd0,        32'd0,        32'd0,        1'b0, 0},
        '{4'd7,  32'd5,        32'd3,        32'd1,        32'd0,        1'b0, 0},
        '{4'd9,  32'd1,        32'd33,       32'd2,        32'd0,        1'b0, 0},
        '{4'd10, 32'h80000000, 32'd31,       32'd1,        32'd0,        1'b0, 0},
        '{4'd3,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'd0,        1'b0, 0},
        '{4'd4,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 32'd0,        1'b0, 0},
        '{4'd0,  32'h12345678, 32'd1,        32'd0,        32'd0,        1'b0, 0},
        '{4'd12, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 34},
        '{4'd13, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd1,        1'b0, 34},
        '{4'd12, 32'h80000000, 32'h80000000, 32'd0,        32'h40000000, 1'b0, 34},
        '{4'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34},
        '{4'd15, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 34},
        '{4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34},
        '{4'd14, 32'hFFFFFFFB, 32'd0,        32'd1,        32'hFFFFFFFB, 1'b0, 34},
        '{4'd14, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34},
        '{4'd15, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34}
    };

    alu_seq #(.WIDTH(32), .MD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl), .a1(a1), .a2(a2),
        .busy(busy), .done(done), .alu_out(alu_out), .hi_out(hi_out), .zero(zero), .ovf(ovf)
    );
    alu_seq #(.WIDTH(8), .MD_EN(1'b0)) dut8 (
        .clk(clk), .rst(rst), .start(s_start), .alu_ctrl(s_ctrl), .a1(s_a1), .a2(s_a2),
        .busy(s_busy), .done(s_done), .alu_out(s_out), .hi_out(s_hi), .zero(s_zero), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; alu_ctrl = op; a1 = x; a2 = y;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        s_start = 1'b1; s_ctrl = op; s_a1 = x; s_a2 = y;
        @(posedge clk); #1;
        s_start = 1'b0;
        edges = 0;
        while (!s_done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!s_done) chk("done8_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n, first;
        rst = 1'b1; start = 1'b0; alu_ctrl = '0; a1 = '0; a2 = '0;
        s_start = 1'b0; s_ctrl = '0; s_a1 = '0; s_a2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", alu_out, 0);
        chk("rst_hi", hi_out, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst8_out", s_out, 0);
        @(negedge clk) rst = 1'b0;

        @(negedge clk);
        start = 1'b1; alu_ctrl = 4'd1; a1 = 32'h7FFFFFFF; a2 = 32'd1;
        @(posedge clk); #1;
        chk("add_done", done, 1);
        chk("add_out", alu_out, 32'h80000000);
        chk("add_ovf", ovf, 1);
        chk("add_zero", zero, 0);
        chk("add_hi", hi_out, 0);
        @(negedge clk);
        alu_ctrl = 4'd2; a1 = 32'd5; a2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        chk("sub_done", done, 1);
        chk("sub_out", alu_out, 0);
        chk("sub_zero", zero, 1);
        chk("sub_ovf", ovf, 0);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);

        for (int i = 0; i < $size(vecs); i++) begin
            run(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_op%0d_lat", i, vecs[i].op), 64'(edges), 64'(vecs[i].lat));
            chk($sformatf("v%0d_op%0d_lo", i, vecs[i].op), alu_out, vecs[i].lo);
            chk($sformatf("v%0d_op%0d_hi", i, vecs[i].op), hi_out, vecs[i].hi);
            chk($sformatf("v%0d_op%0d_ovf", i, vecs[i].op), ovf, vecs[i].ov);
            chk($sformatf("v%0d_op%0d_zero", i, vecs[i].op), zero, vecs[i].lo == 32'd0);
        end

        @(negedge clk);
        start = 1'b1; alu_ctrl = 4'd12; a1 = 32'd6; a2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("md_busy", busy, 1);
        n = 0; first = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 3) begin
                @(negedge clk);
                start = 1'b1; alu_ctrl = 4'd1; a1 = 32'd1; a2 = 32'd1;
            end
            if (i == 5) begin
                @(negedge clk);
                a1 = 32'd100; a2 = 32'd100;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                n++;
                if (first < 0) first = i;
            end
        end
        chk("ign_ndone", 64'(n), 64'd1);
        chk("ign_edge", 64'(first), 64'd34);
        chk("ign_lo", alu_out, 32'd42);
        chk("ign_hi", hi_out, 0);

        @(negedge clk);
        start = 1'b1; alu_ctrl = 4'd14; a1 = 32'd100; a2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_out", alu_out, 0);
        chk("abort_hi", hi_out, 0);
        chk("abort_zero", zero, 0);
        chk("abort_ovf", ovf, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        chk("abort_quiet", 64'(n), 64'd0);

        run8(4'd12, 8'd3, 8'd5);
        chk("w8_mult_lat", 64'(edges), 64'd0);
        chk("w8_mult_lo", s_out, 0);
        chk("w8_mult_hi", s_hi, 0);
        chk("w8_mult_zero", s_zero, 1);
        chk("w8_mult_busy", s_busy, 0);
        run8(4'd1, 8'h7F, 8'h01);
        chk("w8_add_out", s_out, 8'h80);
        chk("w8_add_ovf", s_ovf, 1);
        run8(4'd11, 8'h80, 8'd9);
        chk("w8_sra_out", s_out, 8'hC0);
        run8(4'd15, 8'd9, 8'd0);
        chk("w8_divu_lat", 64'(edges), 64'd0);
        chk("w8_divu_lo", s_out, 0);
        chk("w8_divu_hi", s_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
